// File: rtl/chan_mux_rr.sv
// N-channel registered stream multiplexer with manual select or round-robin
// arbitration (bursts of up to BURST words per grant) and one output register.
module chan_mux_rr #(
    parameter int N_CH  = 4,
    parameter int W     = 8,
    parameter int BURST = 1,
    parameter int SEL_W = $clog2(N_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              mode,
    input  logic [SEL_W-1:0]  sel,
    input  logic [N_CH*W-1:0] d,
    input  logic [N_CH-1:0]   in_valid,
    output logic [N_CH-1:0]   in_ready,
    output logic [W-1:0]      y,
    output logic [SEL_W-1:0]  out_ch,
    output logic              out_valid,
    input  logic              out_ready
);
    localparam int BC_W = $clog2(BURST + 1);
    localparam logic [BC_W-1:0] BURST_C = BC_W'(BURST);
    localparam logic [SEL_W:0] NCH_C = (SEL_W + 1)'(N_CH);

    typedef enum logic {SEARCH, HOLD} state_t;

    state_t           state_reg, state_next;
    logic [SEL_W-1:0] ptr_reg, ptr_next;
    logic [BC_W-1:0]  bcnt_reg, bcnt_next;
    logic [W-1:0]     y_reg;
    logic [SEL_W-1:0] out_ch_reg;
    logic             out_valid_reg;

    logic [W-1:0]     d_ch [N_CH];
    logic [SEL_W-1:0] cand_idx [N_CH];
    logic [N_CH-1:0]  cand_valid;

    logic [SEL_W-1:0] g;
    logic [SEL_W-1:0] scan_g;
    logic             scan_ok;
    logic             sel_valid;
    logic             ptr_valid;
    logic             hold_grant;
    logic             grant_ok;
    logic             free;
    logic             accept;
    logic [BC_W-1:0]  bcnt_inc;

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_chan
            // Candidate gi is the (gi+1)-th channel after ptr, wrapping modulo N_CH.
            localparam logic [SEL_W:0] OFF = (SEL_W + 1)'(gi + 1);
            logic [SEL_W:0] sum;
            assign sum           = {1'b0, ptr_reg} + OFF;
            assign cand_idx[gi]  = (sum >= NCH_C) ? SEL_W'(sum - NCH_C) : SEL_W'(sum);
            assign cand_valid[gi] = in_valid[cand_idx[gi]];
            assign d_ch[gi]      = d[gi*W +: W];
            assign in_ready[gi]  = accept && (g == SEL_W'(gi));
        end
    endgenerate

    always_comb begin
        scan_ok = 1'b0;
        scan_g  = '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (cand_valid[k]) begin
                scan_ok = 1'b1;
                scan_g  = cand_idx[k];
            end
        end
        // Out-of-range sel matches no channel and therefore never grants.
        sel_valid = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (sel == SEL_W'(k)) sel_valid = in_valid[k];
        end
    end

    assign ptr_valid  = in_valid[ptr_reg];
    assign hold_grant = mode && (state_reg == HOLD) && ptr_valid;
    assign free       = !out_valid_reg || out_ready;
    assign bcnt_inc   = bcnt_reg + 1'b1;

    always_comb begin
        g        = scan_g;
        grant_ok = scan_ok;
        if (!mode) begin
            g        = sel;
            grant_ok = sel_valid;
        end else if (hold_grant) begin
            g        = ptr_reg;
            grant_ok = 1'b1;
        end
    end

    assign accept = !rst && en && free && grant_ok;

    always_comb begin
        state_next = state_reg;
        ptr_next   = ptr_reg;
        bcnt_next  = bcnt_reg;
        // A burst whose channel went idle is abandoned in the same cycle.
        if (en && free && mode && (state_reg == HOLD) && !ptr_valid) begin
            state_next = SEARCH;
            bcnt_next  = '0;
        end
        if (accept) begin
            ptr_next = g;
            if (!mode) begin
                state_next = SEARCH;
                bcnt_next  = '0;
            end else if (hold_grant) begin
                bcnt_next = bcnt_inc;
                if (bcnt_inc == BURST_C) state_next = SEARCH;
            end else begin
                bcnt_next  = BC_W'(1);
                state_next = (BURST > 1) ? HOLD : SEARCH;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= SEARCH;
            ptr_reg   <= SEL_W'(N_CH - 1);
            bcnt_reg  <= '0;
        end else begin
            state_reg <= state_next;
            ptr_reg   <= ptr_next;
            bcnt_reg  <= bcnt_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            y_reg         <= '0;
            out_ch_reg    <= '0;
            out_valid_reg <= 1'b0;
        end else if (accept) begin
            y_reg         <= d_ch[g];
            out_ch_reg    <= g;
            out_valid_reg <= 1'b1;
        end else if (out_valid_reg && out_ready) begin
            out_valid_reg <= 1'b0;
        end
    end

    assign y         = y_reg;
    assign out_ch    = out_ch_reg;
    assign out_valid = out_valid_reg;

endmodule
